// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// A 4-entry byte FIFO in front of the shifter lets a producer queue bytes mid-frame.
module uart_tx #(
    parameter int CLK     = 50_000_000,
    parameter int BPS     = 9600,
    parameter int BPS_CNT = CLK / BPS,
    parameter int PARITY  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic       dout,
    output logic       busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    localparam logic [15:0] BaudLast = 16'(BPS_CNT - 1);

    logic [7:0]  r_fifo [4];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic [2:0]  r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_dout;
    logic        r_busy;

    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_baud_done;
    logic        w_par_bit;
    logic [2:0]  w_state_d;
    logic        w_dout_d;

    assign w_full      = (r_count == 3'd4);
    assign w_empty     = (r_count == 3'd0);
    assign din_rdy     = !w_full && !rst;
    assign w_push      = din_vld && din_rdy;
    assign w_baud_done = (r_baud == BaudLast);
    // r_par holds the XOR of the data byte; odd parity inverts it
    assign w_par_bit   = (PARITY == 1) ? ~r_par : r_par;
    assign dout        = r_dout;
    assign busy        = r_busy;

    always_comb begin
        w_state_d = r_state;
        w_dout_d  = r_dout;
        w_pop     = 1'b0;
        case (r_state)
            StIdle: begin
                w_dout_d = 1'b1;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = StStart;
                    w_dout_d  = 1'b0;
                end
            end
            StStart: begin
                if (w_baud_done) begin
                    w_state_d = StData;
                    w_dout_d  = r_shift[0];
                end
            end
            StData: begin
                if (w_baud_done) begin
                    if (r_bit != 3'd7) begin
                        w_dout_d = r_shift[1];
                    end else if (PARITY != 0) begin
                        w_state_d = StParity;
                        w_dout_d  = w_par_bit;
                    end else begin
                        w_state_d = StStop;
                        w_dout_d  = 1'b1;
                    end
                end
            end
            StParity: begin
                if (w_baud_done) begin
                    w_state_d = StStop;
                    w_dout_d  = 1'b1;
                end
            end
            StStop: begin
                if (w_baud_done) begin
                    // Chain straight into the next start bit when more bytes are queued
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = StStart;
                        w_dout_d  = 1'b0;
                    end else begin
                        w_state_d = StIdle;
                        w_dout_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_dout_d  = 1'b1;
            end
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_state <= StIdle;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_dout  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_dout  <= w_dout_d;
            r_busy  <= (r_state != StIdle) || !w_empty;

            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end

            if (w_pop) begin
                r_rptr  <= r_rptr + 2'd1;
                r_shift <= r_fifo[r_rptr];
                r_par   <= ^r_fifo[r_rptr];
                r_bit   <= 3'd0;
            end else if (r_state == StData && w_baud_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase

            if (r_state == StIdle || w_state_d != r_state || w_baud_done) begin
                r_baud <= 16'd0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no/odd/even parity) share one stimulus,
// BPS_CNT = 10.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_vld;
    logic       rdy0, rdy1, rdy2;
    logic       dout0, dout1, dout2;
    logic       busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.CLK(1_000_000), .BPS(100_000), .PARITY(0)) u_p0 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .din_rdy(rdy0), .dout(dout0), .busy(busy0)
    );
    uart_tx #(.CLK(1_000_000), .BPS(100_000), .PARITY(1)) u_p1 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .din_rdy(rdy1), .dout(dout1), .busy(busy1)
    );
    uart_tx #(.CLK(1_000_000), .BPS(100_000), .PARITY(2)) u_p2 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .din_rdy(rdy2), .dout(dout2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        din_vld = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    // Frame bit b of a no-parity frame: start, d[0..7], stop
    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b >= 1 && b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; din_vld = 1'b0; din = 8'h00;
        tick();
        n_checks++;
        if (dout0 !== 1'b1) begin n_fail++; $display("FAIL reset_dout: got %b required 1", dout0); end
        n_checks++;
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy0); end
        n_checks++;
        if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_low: got %b required 0", rdy0); end
        n_checks++;
        if (dout2 !== 1'b1) begin n_fail++; $display("FAIL reset_dout_p2: got %b required 1", dout2); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_release: got %b required 1", rdy0); end
        tick();
        n_checks++;
        if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got rdy=%b busy=%b required rdy=1 busy=0", rdy0, busy0);
        end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_checks++;
            if (dout0 !== 1'b1 || busy0 !== 1'b0 || dout1 !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d: got dout=%b busy=%b dout_p1=%b required 1,0,1",
                         i, dout0, busy0, dout1);
            end
        end
    endtask

    task automatic test_single_parity();
        logic [9:0]  seq0;
        logic [10:0] seq1;
        logic [10:0] seq2;
        logic        e0, e1, e2, eb0, eb12;
        seq0 = 10'b1101001010;   // A5: 0,1,0,1,0,0,1,0,1,1 LSB first
        seq1 = 11'b11101001010;  // odd parity bit 1
        seq2 = 11'b10101001010;  // even parity bit 0
        apply_reset();
        din = 8'hA5; din_vld = 1'b1;
        tick();  // write edge E0
        din_vld = 1'b0;
        n_checks++;
        if (dout0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e0: got dout=%b busy=%b required 1,0", dout0, busy0);
        end
        for (int cyc = 1; cyc <= 115; cyc++) begin
            tick();
            e0   = (cyc <= 100) ? seq0[(cyc-1)/10] : 1'b1;
            e1   = (cyc <= 110) ? seq1[(cyc-1)/10] : 1'b1;
            e2   = (cyc <= 110) ? seq2[(cyc-1)/10] : 1'b1;
            eb0  = (cyc <= 101);
            eb12 = (cyc <= 111);
            n_checks++;
            if (dout0 !== e0) begin
                n_fail++; $display("FAIL single_dout cyc %0d: got %b required %b", cyc, dout0, e0);
            end
            n_checks++;
            if (busy0 !== eb0) begin
                n_fail++; $display("FAIL single_busy cyc %0d: got %b required %b", cyc, busy0, eb0);
            end
            n_checks++;
            if (dout1 !== e1) begin
                n_fail++; $display("FAIL odd_dout cyc %0d: got %b required %b", cyc, dout1, e1);
            end
            n_checks++;
            if (dout2 !== e2) begin
                n_fail++; $display("FAIL even_dout cyc %0d: got %b required %b", cyc, dout2, e2);
            end
            n_checks++;
            if (busy1 !== eb12 || busy2 !== eb12) begin
                n_fail++;
                $display("FAIL parity_busy cyc %0d: got %b/%b required %b", cyc, busy1, busy2, eb12);
            end
        end
    endtask

    // Five pushes fill the FIFO (one byte pops immediately); 06 is held and lands
    // only after the STOP->START pop, which itself refuses the coinciding push.
    task automatic test_burst_full();
        logic       e;
        logic       er;
        logic [7:0] b;
        apply_reset();
        din = 8'h01; din_vld = 1'b1;
        tick();  // E0
        for (int cyc = 1; cyc <= 605; cyc++) begin
            if (cyc <= 4) begin
                din = 8'(cyc + 1);
                n_checks++;
                if (rdy0 !== 1'b1) begin
                    n_fail++; $display("FAIL burst_accept byte %0d: got rdy=%b required 1", cyc + 1, rdy0);
                end
            end else if (cyc == 5) begin
                din = 8'h06;
            end
            tick();  // now after edge E0+cyc
            if (cyc <= 600) begin
                b = 8'((cyc - 1) / 100 + 1);
                e = frame_bit(b, ((cyc - 1) % 100) / 10);
            end else begin
                e = 1'b1;
            end
            n_checks++;
            if (dout0 !== e) begin
                n_fail++; $display("FAIL burst_dout cyc %0d: got %b required %b", cyc, dout0, e);
            end
            n_checks++;
            if (busy0 !== (cyc <= 601)) begin
                n_fail++; $display("FAIL burst_busy cyc %0d: got %b required %b", cyc, busy0, cyc <= 601);
            end
            if (cyc >= 4 && cyc <= 102) begin
                er = (cyc == 101);
                n_checks++;
                if (rdy0 !== er) begin
                    n_fail++; $display("FAIL burst_rdy cyc %0d: got %b required %b", cyc, rdy0, er);
                end
            end
            if (cyc == 102) din_vld = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic e;
        apply_reset();
        din = 8'hA5; din_vld = 1'b1;
        tick();  // E0
        din = 8'h3C;
        tick();  // E0+1: pop A5, push 3C
        din_vld = 1'b0;
        for (int cyc = 2; cyc <= 45; cyc++) tick();
        n_checks++;
        if (dout0 !== 1'b0) begin
            n_fail++; $display("FAIL midframe_bit3: got %b required 0", dout0);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (dout0 !== 1'b1 || busy0 !== 1'b0 || rdy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got dout=%b busy=%b rdy=%b required 1,0,0",
                     dout0, busy0, rdy0);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdy0 !== 1'b1) begin
            n_fail++; $display("FAIL midframe_rdy: got %b required 1", rdy0);
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            n_checks++;
            if (dout0 !== 1'b1 || busy0 !== 1'b0 || dout2 !== 1'b1) begin
                n_fail++;
                $display("FAIL midframe_quiet cyc %0d: got dout=%b busy=%b dout_p2=%b required 1,0,1",
                         i, dout0, busy0, dout2);
            end
        end
        din = 8'h5A; din_vld = 1'b1;
        tick();  // new write edge
        din_vld = 1'b0;
        for (int cyc = 1; cyc <= 103; cyc++) begin
            tick();
            e = (cyc <= 100) ? frame_bit(8'h5A, (cyc - 1) / 10) : 1'b1;
            n_checks++;
            if (dout0 !== e) begin
                n_fail++; $display("FAIL after_reset_dout cyc %0d: got %b required %b", cyc, dout0, e);
            end
            n_checks++;
            if (busy0 !== (cyc <= 101)) begin
                n_fail++;
                $display("FAIL after_reset_busy cyc %0d: got %b required %b", cyc, busy0, cyc <= 101);
            end
        end
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; din_vld = 1'b0;
        test_reset();
        test_idle_hold();
        test_single_parity();
        test_burst_full();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
